// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - start/data/parity/stop serial framer with valid/ready word output
module serial_frame_rx #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_en,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             word_perr,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             par;
    logic             perr;

    logic frame_ok;
    logic frame_bad;
    logic slot_free;

    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (si_en && state == S_STOP) begin
            frame_ok  = si;
            frame_bad = !si;
        end
        // The slot can take a new word if empty or being drained on this same edge
        slot_free = !word_valid || out_ready;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            sh    <= '0;
            cnt   <= '0;
            par   <= 1'b0;
            perr  <= 1'b0;
        end else if (si_en) begin
            case (state)
                S_IDLE: begin
                    if (!si) begin
                        state <= S_DATA;
                        cnt   <= '0;
                        par   <= 1'b0;
                    end
                end
                S_DATA: begin
                    sh  <= {sh[WIDTH-2:0], si};
                    cnt <= cnt + CW'(1);
                    par <= par ^ si;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    perr  <= par ^ si;
                    state <= S_STOP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word       <= '0;
            word_valid <= 1'b0;
            word_perr  <= 1'b0;
        end else if (frame_ok && slot_free) begin
            word       <= sh;
            word_perr  <= perr;
            word_valid <= 1'b1;
        end else if (word_valid && out_ready) begin
            word_valid <= 1'b0;
        end
    end

    // Sticky flags: a set condition beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (frame_ok && !slot_free) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed bench for serial_frame_rx with a bit-queue reference model
module tb_serial_frame_rx;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         si = 1'b1;
    logic         si_en = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] word;
    logic         word_valid;
    logic         word_perr;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .si         (si),
        .si_en      (si_en),
        .out_ready  (out_ready),
        .clr_err    (clr_err),
        .word       (word),
        .word_valid (word_valid),
        .word_perr  (word_perr),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect strobed bits from a start bit until a whole frame is in hand
    int           m_bits[$];
    logic [W-1:0] m_word  = '0;
    logic         m_valid = 1'b0;
    logic         m_perr  = 1'b0;
    logic         m_ferr  = 1'b0;
    logic         m_ovr   = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        logic [W-1:0] d;
        int           ones;
        logic         done_ok;
        logic         done_bad;
        logic         set_ovr;
        if (!rst) begin
            m_bits.delete();
            m_word  = '0;
            m_valid = 1'b0;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            done_ok  = 1'b0;
            done_bad = 1'b0;
            d        = '0;
            ones     = 0;
            if (si_en && (m_bits.size() > 0 || si == 1'b0)) begin
                m_bits.push_back(int'(si));
            end
            if (m_bits.size() == W + 3) begin
                for (int i = 1; i <= W; i++) d = {d[W-2:0], m_bits[i][0]};
                for (int i = 1; i <= W + 1; i++) ones += m_bits[i];
                if (m_bits[W+2] == 1) done_ok = 1'b1;
                else done_bad = 1'b1;
                m_bits.delete();
            end
            set_ovr = done_ok && m_valid && !out_ready;
            if (done_ok && (!m_valid || out_ready)) begin
                m_word  = d;
                m_perr  = ones[0];
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (done_bad) m_ferr = 1'b1;
            else if (clr_err) m_ferr = 1'b0;
            if (set_ovr) m_ovr = 1'b1;
            else if (clr_err) m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_bits.size() != 0));
        check("word_valid", 32'(word_valid), 32'(m_valid));
        if (m_valid) begin
            check("word", 32'(word), 32'(m_word));
            check("word_perr", 32'(word_perr), 32'(m_perr));
        end
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("overrun", 32'(overrun), 32'(m_ovr));
    end

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap - 1; g++) begin
            si_en = 1'b0;
            si    = b;
            @(negedge clk);
        end
        si    = b;
        si_en = 1'b1;
        @(negedge clk);
        si_en = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop,
                              input int gap, input logic rdy_stop);
        send_bit(1'b0, gap);
        for (int i = W - 1; i >= 0; i--) send_bit(d[i], gap);
        send_bit(p, gap);
        if (rdy_stop) out_ready = 1'b1;
        send_bit(stop, gap);
        si = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(word_valid), 0);
        check("rst_word", 32'(word), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ferr", 32'(frame_err), 0);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        send_frame(5'b10110, 1'b1, 1'b1, 1, 1'b0);
        check("basic_valid", 32'(word_valid), 1);
        check("basic_word", 32'(word), 32'h16);
        check("basic_perr", 32'(word_perr), 0);
        @(negedge clk);
        check("basic_one_cycle", 32'(word_valid), 0);

        send_frame(5'b10110, 1'b0, 1'b1, 1, 1'b0);
        check("perr_word", 32'(word), 32'h16);
        check("perr_flag", 32'(word_perr), 1);
        check("perr_ferr", 32'(frame_err), 0);
        check("perr_ovr", 32'(overrun), 0);
        @(negedge clk);

        send_frame(5'b00001, 1'b1, 1'b0, 1, 1'b0);
        check("ferr_novalid", 32'(word_valid), 0);
        check("ferr_set", 32'(frame_err), 1);
        pulse_clr();
        check("ferr_clr", 32'(frame_err), 0);
        send_frame(5'b11111, 1'b1, 1'b1, 1, 1'b0);
        check("after_ferr_word", 32'(word), 32'h1f);
        check("after_ferr_valid", 32'(word_valid), 1);
        @(negedge clk);

        out_ready = 1'b0;
        send_frame(5'b00011, 1'b0, 1'b1, 1, 1'b0);
        send_frame(5'b11100, 1'b1, 1'b1, 1, 1'b0);
        check("ovr_word", 32'(word), 32'h03);
        check("ovr_flag", 32'(overrun), 1);
        pulse_clr();
        check("ovr_clr", 32'(overrun), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ovr_drained", 32'(word_valid), 0);
        send_frame(5'b00011, 1'b0, 1'b1, 1, 1'b0);
        send_frame(5'b11100, 1'b1, 1'b1, 1, 1'b1);
        check("simul_word", 32'(word), 32'h1c);
        check("simul_valid", 32'(word_valid), 1);
        check("simul_ovr", 32'(overrun), 0);
        @(negedge clk);

        send_frame(5'b01010, 1'b0, 1'b1, 4, 1'b0);
        check("gap_word", 32'(word), 32'h0a);
        check("gap_perr", 32'(word_perr), 0);
        check("gap_busy_done", 32'(busy), 0);
        @(negedge clk);

        out_ready = 1'b0;
        send_frame(5'b11111, 1'b1, 1'b1, 1, 1'b0);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        check("mid_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("async_valid", 32'(word_valid), 0);
        check("async_word", 32'(word), 0);
        check("async_busy", 32'(busy), 0);
        check("async_perr", 32'(word_perr), 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send_frame(5'b10001, 1'b0, 1'b1, 1, 1'b0);
        check("post_rst_word", 32'(word), 32'h11);
        check("post_rst_perr", 32'(word_perr), 0);
        check("post_rst_valid", 32'(word_valid), 1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receive stage that sits directly upstream of the 5-bit shift register consumers.
- Frames a single-wire serial stream (start bit, WIDTH data bits MSB-first, even parity bit, stop bit) into parallel words.
- Delivers each word over a valid/ready handshake with parity, framing and overrun status.
- MSB-first ordering matches the team's left-shift convention {reg[WIDTH-2:0], si}: the first data bit ends in the MSB.

Parameters:
- WIDTH, 5, data bits per frame (2..16).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- si  in  1  serial line; idles high
- si_en  in  1  bit strobe; si is sampled only in cycles with si_en=1
- out_ready  in  1  consumer can accept word
- clr_err  in  1  synchronous clear of sticky frame_err/overrun
- word  out  WIDTH  received data, held stable while word_valid=1
- word_valid  out  1  word available
- word_perr  out  1  parity error for the presented word; qualified by word_valid
- frame_err  out  1  sticky: stop bit sampled 0
- overrun  out  1  sticky: completed frame dropped because output slot was full
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset is asynchronous, active-low: rst=0 immediately forces state=IDLE and clears the shift register, bit counter, word, word_valid, word_perr, frame_err, overrun and busy to 0.
- Reset mid-frame discards the partial frame. After release, the receiver waits for a fresh start bit.
- All state changes below occur only on clk edges where si_en=1, except the output handshake and clr_err.

FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: si=0 goes to DATA with cnt=0. si=1 stays in IDLE.
- DATA: shift sh <= {sh[WIDTH-2:0], si}, cnt++, par ^= si. When cnt reaches WIDTH-1 (the last bit is shifted), go to PARITY.
- PARITY: perr <= par ^ si (even parity: the total count of ones across data+parity must be even). Go to STOP.
- STOP:
  - si=1: the frame is complete. Attempt delivery (below) and go to IDLE.
  - si=0: set frame_err=1, discard the frame with no delivery and no overrun, and go to IDLE. A following si=0 is not treated as a start until sampled again in IDLE.

Delivery and handshake:
- word_valid rises the cycle after the stop-bit sample edge (1-cycle latency). word and word_perr load on the same edge.
- The transfer occurs on an edge with word_valid=1 and out_ready=1. word_valid drops next cycle unless a new word loads on the same edge.
- Frame completes while the slot is empty, or while the slot is being accepted on the same edge: load the new word and keep word_valid=1. No overrun.
- Frame completes while word_valid=1 and out_ready=0: keep the old word and set overrun=1. The new word is lost.
- word and word_perr do not change while word_valid=1 and no transfer occurs.

Status flags:
- frame_err and overrun stay set until clr_err=1 or reset.
- If clr_err=1 and a set condition occur on the same edge, set wins.

Counting:
- cnt is $clog2(WIDTH) bits wide. par resets to 0 on the IDLE→DATA transition.
- si_en gaps of any length are legal mid-frame; the state holds.

busy is combinational from state and is 1 for DATA, PARITY and STOP.

Test Plan:
- Basic frame, WIDTH=5, si_en every cycle, out_ready=1. Send 0,1,0,1,1,0,1,1 (start, data 10110, parity 1, stop) -> word=5'b10110, word_valid=1 for 1 cycle exactly 1 clk after the stop sample, word_perr=0.
- Parity error: same frame with parity bit 0 -> word=5'b10110, word_perr=1; frame_err=0, overrun=0.
- Framing and clear: data 5'b00001, parity 1, stop 0 -> no word_valid, frame_err=1. Then pulse clr_err -> frame_err=0. A next valid frame 5'b11111 (parity 1) delivers normally.
- Overrun and simultaneous accept:
  - With out_ready=0, send 5'b00011 then 5'b11100 -> word stays 5'b00011 and overrun=1.
  - Repeat after clr_err, raising out_ready exactly on the second frame's delivery edge -> 5'b00011 is accepted, word becomes 5'b11100 with word_valid=1, overrun=0.
- Strobe gaps: si_en=1 only every 4th cycle, frame 5'b01010 (parity 0) -> same result as continuous strobing; busy=1 from the start-bit sample until the stop-bit sample.
- Reset mid-frame: drop rst after 3 data bits -> all outputs 0 immediately with no clock edge required. After release, a full frame 5'b10001 (parity 0) is received correctly.
